// File: rtl/rr_burst_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_sched_pkg
// Description : Shared types, default parameters and helpers for the
//               round-robin burst scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_sched_pkg;

  localparam int DEF_NUM_PORTS   = 4;
  localparam int DEF_MAX_BEATS   = 16;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_e;

  // Returns the position of the highest set bit; callers pass a one-hot value.
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_burst_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_burst_sched_if
// Description : Request/grant/beat bundle between requesters, the shared
//               resource and the burst scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_burst_sched_if #(
  parameter int NUM_PORTS = 4,
  parameter int LW        = 4,
  parameter int IDW       = 2
);

  logic [NUM_PORTS-1:0]         req_i;
  logic [NUM_PORTS-1:0][LW-1:0] len_i;
  logic                         beat_i;
  logic [NUM_PORTS-1:0]         gnt_o;
  logic [IDW-1:0]               gnt_id_o;
  logic                         busy_o;
  logic                         last_o;
  logic                         timeout_o;

  modport master (
    output req_i, len_i, beat_i,
    input  gnt_o, gnt_id_o, busy_o, last_o, timeout_o
  );

  modport slave (
    input  req_i, len_i, beat_i,
    output gnt_o, gnt_id_o, busy_o, last_o, timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/rr_burst_sched_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker with an exclude mask.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDW       = $clog2(NUM_PORTS)
) (
  input  wire  [NUM_PORTS-1:0] req,
  input  wire  [IDW-1:0]       ptr,
  input  wire  [NUM_PORTS-1:0] excl,
  output logic [NUM_PORTS-1:0] win_oh,
  output logic [IDW-1:0]       win_idx,
  output logic                 valid
);

  logic [NUM_PORTS-1:0] cand;
  logic [IDW-1:0]       k;

  assign cand  = req & ~excl;
  assign valid = |cand;

  // Scan from the farthest offset back to ptr so the nearest candidate wins.
  always_comb begin
    win_oh = '0;
    k      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      k = IDW'((int'(ptr) + i) % NUM_PORTS);
      if (cand[k]) begin
        win_oh    = '0;
        win_oh[k] = 1'b1;
      end
    end
  end

  assign win_idx = IDW'(onehot_to_idx(32'(win_oh)));

endmodule
`default_nettype wire

// File: rtl/rr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : rr_burst_sched
// Description : Round-robin scheduler that holds a grant for a whole burst.
//               Define RR_SCHED_TIMEOUT_EN to build the stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_burst_sched
  import rr_sched_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int MAX_BEATS   = DEF_MAX_BEATS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input wire             clk,
  input wire             reset,
  rr_burst_sched_if.slave bus
);

  localparam int             LW      = $clog2(MAX_BEATS);
  localparam int             IDW     = $clog2(NUM_PORTS);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_PORTS - 1);

  if (NUM_PORTS < 2 || (1 << LW) != MAX_BEATS || TIMEOUT_CYC < 1) begin : g_param_check
    $error("rr_burst_sched: illegal parameter set");
  end

  rr_state_e            state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        len_q, len_d;

  logic [IDW-1:0]       next_ptr;
  logic [IDW-1:0]       pick_ptr;
  logic [IDW-1:0]       pick_idx;
  logic [NUM_PORTS-1:0] pick_excl;
  logic [NUM_PORTS-1:0] pick_oh;
  logic                 pick_valid;
  logic                 final_beat;
  logic                 stall_hit;

  assign next_ptr   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
  assign final_beat = (state_q == GRANT) && bus.beat_i && (cnt_q == len_q);

  // One picker serves both paths: on the final beat it looks past the
  // current winner, which is also masked out of this round.
  assign pick_ptr  = final_beat ? next_ptr : ptr_q;
  assign pick_excl = final_beat ? gnt_q : '0;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDW       (IDW)
  ) u_pick (
    .req     (bus.req_i),
    .ptr     (pick_ptr),
    .excl    (pick_excl),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

`ifdef RR_SCHED_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          timeout_q;

  always_comb begin
    stall_d = '0;
    if (state_q == GRANT && !bus.beat_i) stall_d = stall_q + 1'b1;
  end

  assign stall_hit = (state_q == GRANT) && !bus.beat_i &&
                     (stall_q == SW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= stall_hit;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign stall_hit     = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = GRANT;
          gnt_d    = pick_oh;
          gnt_id_d = pick_idx;
          len_d    = bus.len_i[pick_idx];
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (final_beat) begin
          ptr_d = next_ptr;
          if (pick_valid) begin
            gnt_d    = pick_oh;
            gnt_id_d = pick_idx;
            len_d    = bus.len_i[pick_idx];
            cnt_d    = '0;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end else if (bus.beat_i) begin
          cnt_d = cnt_q + 1'b1;
        end else if (stall_hit) begin
          ptr_d    = next_ptr;
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.gnt_id_o = gnt_id_q;
  assign bus.busy_o   = (state_q == GRANT);
  assign bus.last_o   = (state_q == GRANT) && (cnt_q == len_q);

endmodule
`default_nettype wire
